// File: rtl/router_pkg.sv
// router_pkg: definitions shared by the router destination reader and the
// source-side packet generator.
//   - FSM state encoding (enum plus legacy-compatible localparam constants)
//   - Header field positions: [1:0] = addr, [7:2] = payload length
//   - ROUTER_TIMEOUT: cycles the router waits for a read before it flushes
//     the port. START_DELAY on the reader must stay below this value.
//   - Helpers that decode the header fields
package router_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    READ = 2'd2,
    DONE = 2'd3
  } router_state_e;

  localparam logic [1:0] ST_IDLE = IDLE;
  localparam logic [1:0] ST_WAIT = WAIT;
  localparam logic [1:0] ST_READ = READ;
  localparam logic [1:0] ST_DONE = DONE;

  localparam int HDR_ADDR_LSB = 0;
  localparam int HDR_ADDR_MSB = 1;
  localparam int HDR_LEN_LSB  = 2;
  localparam int HDR_LEN_MSB  = 7;

  localparam int ROUTER_TIMEOUT = 30;

  // Header and parity bytes that surround the payload
  localparam logic [6:0] PKT_OVERHEAD = 7'd2;

  function automatic logic [5:0] hdr_len(input logic [7:0] hdr);
    return hdr[HDR_LEN_MSB:HDR_LEN_LSB];
  endfunction

  function automatic logic [1:0] hdr_addr(input logic [7:0] hdr);
    return hdr[HDR_ADDR_MSB:HDR_ADDR_LSB];
  endfunction

endpackage

// File: rtl/router_parity_acc.sv
// router_parity_acc: running XOR accumulator over a byte stream.
// The reader and the source-side packet generator both use it.
// Ports:
//   clock     in   clock
//   resetn    in   synchronous, active-low reset
//   i_clear   in   zero the accumulator (takes priority over i_enable)
//   i_enable  in   fold i_byte into the accumulator this cycle
//   i_byte    in   DATA_W byte to accumulate
//   o_acc     out  current accumulator value
module router_parity_acc #(
  parameter int DATA_W = 8
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              i_clear,
  input  logic              i_enable,
  input  logic [DATA_W-1:0] i_byte,
  output logic [DATA_W-1:0] o_acc
);

  logic [DATA_W-1:0] r_acc;

  always_ff @(posedge clock) begin
    if (!resetn || i_clear) begin
      r_acc <= '0;
    end else if (i_enable) begin
      r_acc <= r_acc ^ i_byte;
    end
  end

  assign o_acc = r_acc;

endmodule

// File: rtl/router_dest_reader.sv
// router_dest_reader: consumer end of one router output port.
// The reader waits for i_vld_out and then drains one complete packet
// (header, payload, parity) from the port FIFO. It streams each byte out and
// reports completion, address, length and parity status for each packet.
//
// Optional feature: define PARITY_CHECK_EN to build the parity accumulator
// and compare. Without that define, o_parity_err is tied to 0. The parity
// byte is still read and streamed in both builds.
//
// Handshake: while the FSM is in READ, a FIFO read is issued on every cycle
// where o_read_enb=1. o_read_enb follows i_vld_out and is gated off once all
// len+2 reads have been issued. Read data arrives on i_data_out one cycle
// after the read is issued. It appears on o_byte_data with o_byte_valid=1 in
// that same cycle.
//
// Ports:
//   clock          in   clock
//   resetn         in   synchronous, active-low reset
//   i_vld_out      in   port FIFO non-empty
//   i_soft_reset   in   router timed out and flushed this port's FIFO
//   i_data_out     in   FIFO read data (valid the cycle after a read)
//   o_read_enb     out  FIFO read request
//   o_byte_valid   out  o_byte_data holds a received byte
//   o_byte_data    out  received byte
//   o_pkt_done     out  1-cycle pulse: packet completed
//   o_pkt_addr     out  addr of last completed packet
//   o_pkt_len      out  payload length of last completed packet
//   o_parity_err   out  last completed packet failed parity
//   o_pkt_drop     out  1-cycle pulse: packet aborted by soft reset
//   o_fsm_state    out  current FSM state (ST_IDLE/WAIT/READ/DONE)
module router_dest_reader
  import router_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int START_DELAY = 2
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              i_vld_out,
  input  logic              i_soft_reset,
  input  logic [DATA_W-1:0] i_data_out,
  output logic              o_read_enb,
  output logic              o_byte_valid,
  output logic [DATA_W-1:0] o_byte_data,
  output logic              o_pkt_done,
  output logic [1:0]        o_pkt_addr,
  output logic [5:0]        o_pkt_len,
  output logic              o_parity_err,
  output logic              o_pkt_drop,
  output logic [1:0]        o_fsm_state
);

  // A zero start delay skips the WAIT state entirely
  localparam logic [1:0] START_STATE = (START_DELAY == 0) ? ST_READ : ST_WAIT;
  localparam logic [4:0] WAIT_LAST   = 5'((START_DELAY > 0) ? START_DELAY - 1 : 0);

  logic [1:0] r_state;
  logic [1:0] w_next_state;
  logic [4:0] r_wait_cnt;
  logic [6:0] r_issued;   // reads issued for this packet
  logic [6:0] r_rcvd;     // bytes returned for this packet
  logic [6:0] r_total;    // len + 2, valid once the header has returned
  logic [5:0] r_len;
  logic [1:0] r_addr;
  logic       r_rd_pend;  // a read was issued last cycle and not discarded

  logic w_more;
  logic w_ret;
  logic w_hdr;
  logic w_last;
  logic w_abort;

  // Reads 1 and 2 are always needed (header + parity). Read 3 can be issued
  // no earlier than the cycle after the header returns, so r_total is
  // already loaded by the time it is consulted.
  assign w_more     = (r_issued < PKT_OVERHEAD) || (r_issued < r_total);
  assign o_read_enb = (r_state == ST_READ) && i_vld_out && w_more;

  assign w_ret  = r_rd_pend;
  assign w_hdr  = w_ret && (r_rcvd == 7'd0);
  assign w_last = w_ret && (r_rcvd != 7'd0) && (r_rcvd == r_total - 7'd1);

  // If the parity byte returns in the same cycle as a soft reset, the packet
  // completes and is not dropped
  assign w_abort = i_soft_reset &&
                   ((r_state == ST_WAIT) || ((r_state == ST_READ) && !w_last));

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: if (i_vld_out) w_next_state = START_STATE;
      ST_WAIT: begin
        if (w_abort)                      w_next_state = ST_IDLE;
        else if (r_wait_cnt == WAIT_LAST) w_next_state = ST_READ;
      end
      ST_READ: begin
        if (w_last)       w_next_state = ST_DONE;
        else if (w_abort) w_next_state = ST_IDLE;
      end
      ST_DONE: w_next_state = i_vld_out ? START_STATE : ST_IDLE;
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      r_state    <= ST_IDLE;
      r_wait_cnt <= '0;
      r_issued   <= '0;
      r_rcvd     <= '0;
      r_total    <= '0;
      r_len      <= '0;
      r_addr     <= '0;
      r_rd_pend  <= 1'b0;
      o_pkt_done <= 1'b0;
      o_pkt_drop <= 1'b0;
      o_pkt_addr <= '0;
      o_pkt_len  <= '0;
    end else begin
      r_state    <= w_next_state;
      r_wait_cnt <= (r_state == ST_WAIT) ? r_wait_cnt + 5'd1 : 5'd0;
      r_rd_pend  <= o_read_enb && !w_abort;
      o_pkt_done <= w_last;
      o_pkt_drop <= w_abort;

      if (r_state == ST_READ) begin
        r_issued <= r_issued + {6'd0, o_read_enb};
        r_rcvd   <= r_rcvd + {6'd0, w_ret};
      end else begin
        r_issued <= '0;
        r_rcvd   <= '0;
      end

      if (r_state == ST_IDLE) begin
        r_total <= '0;
      end else if (w_hdr) begin
        r_total <= {1'b0, hdr_len(i_data_out[7:0])} + PKT_OVERHEAD;
        r_len   <= hdr_len(i_data_out[7:0]);
        r_addr  <= hdr_addr(i_data_out[7:0]);
      end

      if (w_last) begin
        o_pkt_len  <= r_len;
        o_pkt_addr <= r_addr;
      end
    end
  end

  assign o_byte_valid = r_rd_pend;
  assign o_byte_data  = r_rd_pend ? i_data_out : '0;
  assign o_fsm_state  = r_state;

`ifdef PARITY_CHECK_EN
  logic [DATA_W-1:0] w_acc;

  // The accumulator covers the header and the payload. The parity byte
  // itself is compared against the accumulator and is not folded in.
  router_parity_acc #(.DATA_W(DATA_W)) u_parity_acc (
    .clock    (clock),
    .resetn   (resetn),
    .i_clear  ((r_state == ST_IDLE) || (r_state == ST_DONE)),
    .i_enable (w_ret && !w_last),
    .i_byte   (i_data_out),
    .o_acc    (w_acc)
  );

  always_ff @(posedge clock) begin
    if (!resetn) begin
      o_parity_err <= 1'b0;
    end else if (w_last) begin
      o_parity_err <= (w_acc != i_data_out);
    end
  end
`else
  assign o_parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_router_dest_reader.sv
`timescale 1ns/1ps
module tb_router_dest_reader;

  localparam int DATA_W      = 8;
  localparam int START_DELAY = 2;
`ifdef PARITY_CHECK_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic resetn;
  always #5 clock = ~clock;

  logic              vld_out;
  logic              soft_reset;
  logic [DATA_W-1:0] data_out;
  logic              read_enb;
  logic              byte_valid;
  logic [DATA_W-1:0] byte_data;
  logic              pkt_done;
  logic [1:0]        pkt_addr;
  logic [5:0]        pkt_len;
  logic              parity_err;
  logic              pkt_drop;
  logic [1:0]        fsm_state;

  router_dest_reader #(.DATA_W(DATA_W), .START_DELAY(START_DELAY)) dut (
    .clock        (clock),
    .resetn       (resetn),
    .i_vld_out    (vld_out),
    .i_soft_reset (soft_reset),
    .i_data_out   (data_out),
    .o_read_enb   (read_enb),
    .o_byte_valid (byte_valid),
    .o_byte_data  (byte_data),
    .o_pkt_done   (pkt_done),
    .o_pkt_addr   (pkt_addr),
    .o_pkt_len    (pkt_len),
    .o_parity_err (parity_err),
    .o_pkt_drop   (pkt_drop),
    .o_fsm_state  (fsm_state)
  );

  // ---------------- scoreboard state ----------------
  logic [DATA_W-1:0] fifo_q[$];     // router port FIFO model
  logic [DATA_W-1:0] exp_q[$];      // expected streamed bytes
  logic [31:0]       exp_pkt_q[$];  // {reads[15:9], perr[8], len[7:2], addr[1:0]}

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int rd_cnt   = 0;
  int done_cnt = 0;
  int drop_cnt = 0;
  int first_rd_cyc  = 0;
  int last_rd_cyc   = 0;
  int last_done_cyc = 0;
  bit stall      = 1'b0;
  bit last_rd    = 1'b0;
  bit last_drop  = 1'b0;
  logic [1:0] last_state = 2'd0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic upd_vld();
    vld_out = (fifo_q.size() != 0) && !stall;
  endtask

  // One clock cycle: sample DUT outputs at the falling edge, then after the
  // rising edge present FIFO read data for any read issued in that cycle.
  task automatic step();
    logic [31:0] e;
    @(negedge clock);
    last_rd    = read_enb;
    last_drop  = pkt_drop;
    last_state = fsm_state;
    if (read_enb) begin
      if (rd_cnt == 0) first_rd_cyc = cyc;
      last_rd_cyc = cyc;
      rd_cnt++;
    end
    if (byte_valid) begin
      if (exp_q.size() == 0) check("extra_byte", 32'(byte_valid), 32'd0);
      else                   check("byte_data", 32'(byte_data), 32'(exp_q.pop_front()));
    end
    if (pkt_done) begin
      if (exp_pkt_q.size() == 0) begin
        check("extra_done", 32'(pkt_done), 32'd0);
      end else begin
        e = exp_pkt_q.pop_front();
        check("pkt_addr",   32'(pkt_addr),   32'(e[1:0]));
        check("pkt_len",    32'(pkt_len),    32'(e[7:2]));
        check("parity_err", 32'(parity_err), 32'(e[8]));
        check("pkt_reads",  32'(rd_cnt),     32'(e[15:9]));
      end
      last_done_cyc = cyc;
      done_cnt++;
      rd_cnt = 0;
    end
    if (pkt_drop) begin
      drop_cnt++;
      rd_cnt = 0;
    end
    @(posedge clock);
    #1;
    cyc++;
    if (last_rd && fifo_q.size() != 0) data_out = fifo_q.pop_front();
    else                               data_out = DATA_W'($urandom);
    upd_vld();
  endtask

  // Load one packet into the FIFO. Only the first n_exp bytes are expected
  // on the byte stream; exp_done selects whether a pkt_done is expected.
  task automatic enqueue(input logic [1:0] addr, input logic [5:0] len, input bit bad,
                         input int n_exp, input bit exp_done);
    logic [DATA_W-1:0] b;
    logic [DATA_W-1:0] par;
    int k;
    k = 0;
    b = {len, addr};
    par = b;
    fifo_q.push_back(b);
    if (k < n_exp) exp_q.push_back(b);
    k++;
    for (int i = 0; i < int'(len); i++) begin
      b = DATA_W'($urandom_range(0, 255));
      par = par ^ b;
      fifo_q.push_back(b);
      if (k < n_exp) exp_q.push_back(b);
      k++;
    end
    b = bad ? (par ^ 8'h01) : par;
    fifo_q.push_back(b);
    if (k < n_exp) exp_q.push_back(b);
    if (exp_done)
      exp_pkt_q.push_back({16'd0, 7'(int'(len) + 2), (bad & PAR_EN), len, addr});
    upd_vld();
  endtask

  task automatic run_until_done(input string tag);
    int target;
    target = done_cnt + 1;
    for (int i = 0; i < 300 && done_cnt < target; i++) step();
    if (done_cnt < target) check(tag, 32'(done_cnt), 32'(target));
  endtask

  // ---------------- stimulus ----------------
  int v;
  int d;
  initial begin
    resetn     = 1'b0;
    soft_reset = 1'b0;
    vld_out    = 1'b0;
    data_out   = '0;
    repeat (3) step();
    check("rst_read_enb",   32'(read_enb),   32'd0);
    check("rst_byte_valid", 32'(byte_valid), 32'd0);
    check("rst_byte_data",  32'(byte_data),  32'd0);
    check("rst_pkt_done",   32'(pkt_done),   32'd0);
    check("rst_pkt_addr",   32'(pkt_addr),   32'd0);
    check("rst_pkt_len",    32'(pkt_len),    32'd0);
    check("rst_parity_err", 32'(parity_err), 32'd0);
    check("rst_pkt_drop",   32'(pkt_drop),   32'd0);
    check("rst_state",      32'(fsm_state),  32'd0);
    resetn = 1'b1;
    repeat (2) step();

    // 1: len=3 addr=2 good parity; START_DELAY idle cycles, then 5 back-to-back reads
    enqueue(2'd2, 6'd3, 1'b0, 5, 1'b1);
    v = cyc;
    run_until_done("t1_timeout");
    check("t1_start_lat", 32'(first_rd_cyc - v), 32'(START_DELAY + 1));
    check("t1_read_span", 32'(last_rd_cyc - first_rd_cyc), 32'd4);
    check("t1_bytes_left", 32'(exp_q.size()), 32'd0);

    // 2: bad parity, held after done, then cleared by a good packet
    repeat (2) step();
    enqueue(2'd2, 6'd3, 1'b1, 5, 1'b1);
    run_until_done("t2_bad_timeout");
    repeat (2) step();
    check("t2_err_held", 32'(parity_err), 32'(PAR_EN));
    enqueue(2'd1, 6'd6, 1'b0, 8, 1'b1);
    run_until_done("t2_good_timeout");
    check("t2_err_cleared", 32'(parity_err), 32'd0);

    // 3: len=0 with a second packet already queued behind it -> no over-read
    repeat (2) step();
    enqueue(2'd3, 6'd0, 1'b0, 2, 1'b1);
    enqueue(2'd1, 6'd1, 1'b0, 3, 1'b1);
    run_until_done("t3_len0_timeout");
    run_until_done("t3_next_timeout");

    // 4: vld_out stalls 3 cycles after the 2nd payload read of len=4
    repeat (2) step();
    enqueue(2'd0, 6'd4, 1'b0, 6, 1'b1);
    for (int i = 0; i < 50 && rd_cnt < 3; i++) step();
    check("t4_reach_3", 32'(rd_cnt), 32'd3);
    stall = 1'b1;
    upd_vld();
    for (int i = 0; i < 3; i++) begin
      step();
      check("t4_stall_rd", 32'(last_rd), 32'd0);
    end
    stall = 1'b0;
    upd_vld();
    run_until_done("t4_timeout");

    // 5: soft_reset in READ after 2 reads; the read issued alongside it is discarded
    repeat (2) step();
    enqueue(2'd2, 6'd5, 1'b0, 2, 1'b0);
    for (int i = 0; i < 50 && rd_cnt < 2; i++) step();
    check("t5_reach_2", 32'(rd_cnt), 32'd2);
    soft_reset = 1'b1;
    step();
    soft_reset = 1'b0;
    fifo_q.delete();
    upd_vld();
    step();
    check("t5_drop",     32'(last_drop),  32'd1);
    check("t5_read_enb", 32'(last_rd),    32'd0);
    check("t5_state",    32'(last_state), 32'd0);
    check("t5_len_kept", 32'(pkt_len),    32'd4);
    check("t5_addr_kept", 32'(pkt_addr),  32'd0);
    step();
    check("t5_drop_pulse", 32'(last_drop), 32'd0);

    // 6: len=63 back-to-back with a second packet; DONE goes straight to WAIT
    repeat (2) step();
    enqueue(2'd1, 6'd63, 1'b0, 65, 1'b1);
    enqueue(2'd2, 6'd2, 1'b0, 4, 1'b1);
    run_until_done("t6_long_timeout");
    d = last_done_cyc;
    run_until_done("t6_next_timeout");
    check("t6_b2b_lat", 32'(first_rd_cyc - d), 32'(START_DELAY + 1));

    repeat (3) step();
    check("end_bytes_left", 32'(exp_q.size()),     32'd0);
    check("end_pkts_left",  32'(exp_pkt_q.size()), 32'd0);
    check("end_drop_cnt",   32'(drop_cnt),         32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
